div_ramp_ctrl: RTL and testbench
================================

# div_ramp_ctrl

Rate scheduler for the clock divider. It accepts target divide-count requests over a valid/ready handshake and drives the divider's `count_control` input. Changes are ramped in fixed steps, never jumped, so downstream motor and crane logic clocked from `div_clk` sees bounded acceleration. It sits between the motion-command logic and the divider, and watches the divider's output to pace each step.

## Interface
- `CW`, 26: width of `count_control` and the request value.
- `INIT_COUNT`, 26'd24_999_999: `count_control` value at reset.
- `MIN_COUNT`, 26'd1: lowest legal count; lower requests are clamped up to it.
- `STEP`, 26'd1000: maximum change of `count_control` per ramp step.
- `DWELL`, 4: number of `div_clk` rising edges between ramp steps (≥1).

Ports:
- `clk`, in, 1: system clock. The only clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `div_clk`, in, 1: divider output, synchronous to `clk`. Used only for edge counting.
- `req_valid`, in, 1: target request present.
- `req_ready`, out, 1: request can be accepted.
- `req_count`, in, CW: requested target count.
- `req_abort`, in, 1: stop the ramp and hold the current value.
- `count_control`, out, CW: value driven into the divider.
- `busy`, out, 1: ramp in progress.
- `done`, out, 1: one-cycle pulse when the target is reached.

## Operation
- States are IDLE and RAMP.
- `req_ready` = (state==IDLE), combinational. A handshake occurs when `req_valid` and `req_ready` are both high on a `clk` rising edge.
- Accept in IDLE:
  - Latch `tgt` = max(`req_count`, `MIN_COUNT`).
  - If `tgt` == `count_control`: pulse `done` next cycle and stay in IDLE.
  - Otherwise: go to RAMP, set `busy`=1, clear the edge counter.
- RAMP:
  - Count `div_clk` rising edges, detected as `div_clk` & ~`div_clk_q`.
  - On the `DWELL`-th edge, perform one step and clear the counter. Let `diff` = |`tgt` − `count_control`|:
    - If `diff` ≤ `STEP`: `count_control` ← `tgt`, `done`=1 for one cycle, `busy`←0, go to IDLE.
    - Else: `count_control` ← `count_control` ± `STEP`, toward `tgt`.
- Arithmetic: compare and subtract at CW+1 bits. A step never overshoots `tgt`. No wrap-around is possible because `tgt` bounds the result.
- `req_abort` in RAMP: go to IDLE, keep `count_control` as is, `busy`←0, no `done`. Abort wins over a step in the same cycle. Abort in IDLE is ignored.
- `req_valid` while in RAMP is not accepted. The requester holds `req_valid` and the request is taken on the first IDLE cycle.
- Reset values: `count_control`=`INIT_COUNT`, `busy`=0, `done`=0, state IDLE, edge counter 0, `div_clk_q`=0, `tgt`=`INIT_COUNT`.
- Reset mid-ramp abandons the ramp immediately.

## Timing
- Acceptance at clock edge k gives `busy`=1 from k+1.
- First step happens on the clock edge that samples the `DWELL`-th `div_clk` rise after k. Later steps follow every `DWELL` rises.
- Final step: `count_control`=`tgt`, `done`=1 and `busy`=0 all appear after the same edge. `done` is high for exactly one cycle.
- Same-value request: `done` pulses at k+1 and `busy` stays 0.
- New request can be accepted on the cycle after `done`.
- All outputs are registered except `req_ready`.

## Structure
- Package `div_ctrl_pkg` holds:
  - `CW` default as a localparam.
  - State enum `ramp_state_t` {IDLE, RAMP}.
- Sub-module `div_clk_edge` is a registered rising-edge detector producing a one-`clk` pulse.
- Top level holds the FSM, the edge counter (width $clog2(DWELL+1)) and the step datapath.

## Test plan
Bench parameters: `INIT_COUNT`=100, `STEP`=10, `DWELL`=2, `MIN_COUNT`=1.
- Reset, then release → `count_control`=100, `busy`=0, `done`=0, `req_ready`=1. Asserting `rst` mid-ramp restores these values without waiting for a `clk` edge.
- Request 130 → after 2, 4 and 6 `div_clk` rises `count_control` = 110, 120, 130. `done` pulses once with the 130 update, `busy` falls on the same edge.
- Request 75 from 100 → steps to 90, 80, then 75 (partial final step). No value below 75 ever appears.
- Request 100 while at 100 → `done` pulses the next cycle and `busy` stays 0. Request 0 → clamped, ramps down to 1.
- Abort after the first step of 100→140 → holds 110, `busy`=0, no `done`. Abort coinciding with the final step → value held at its pre-step level, no `done`.
- `req_valid` held with 50 during a ramp → `req_ready`=0 throughout. Accepted on the cycle after `done`, then ramps to 50.

Source files
------------

// File: rtl/div_ramp_ctrl_pkg.sv
// Shared types and defaults for the divide-count ramp scheduler.
package div_ctrl_pkg;

  localparam int unsigned DEF_CW = 26;

  typedef enum logic {
    IDLE,
    RAMP
  } ramp_state_t;

endpackage

// File: rtl/div_ramp_ctrl_if.sv
// Request channel from the motion-command logic into the ramp scheduler.
interface div_ramp_ctrl_if #(
  parameter int unsigned CW = div_ctrl_pkg::DEF_CW
);

  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_count;
  logic          req_abort;

  modport master (
    output req_valid,
    output req_count,
    output req_abort,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_count,
    input  req_abort,
    output req_ready
  );

endinterface

// File: rtl/div_clk_edge.sv
// Rising-edge detector for the divider output; rise is high for one clk cycle.
module div_clk_edge (
  input  logic clk,
  input  logic rst,
  input  logic div_clk,
  output logic rise
);

  logic div_clk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_clk_q <= 1'b0;
    else     div_clk_q <= div_clk;
  end

  assign rise = div_clk & ~div_clk_q;

endmodule

// File: rtl/div_ramp_ctrl.sv
// Ramps the divider count_control toward a requested target in bounded steps,
// one step every DWELL rising edges of div_clk.
module div_ramp_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned   CW         = DEF_CW,
  parameter logic [CW-1:0] INIT_COUNT = CW'(24_999_999),
  parameter logic [CW-1:0] MIN_COUNT  = CW'(1),
  parameter logic [CW-1:0] STEP       = CW'(1000),
  parameter int unsigned   DWELL      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          div_clk,
  div_ramp_ctrl_if.slave req,
  output logic [CW-1:0] count_control,
  output logic          busy,
  output logic          done
);

  localparam int unsigned   EW     = $clog2(DWELL + 1);
  localparam logic [EW-1:0] LAST   = EW'(DWELL - 1);
  localparam logic [CW:0]   STEP_X = {1'b0, STEP};

  ramp_state_t   state_q, state_d;
  logic [EW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tgt_q, tgt_d, cc_d, req_tgt, stepped;
  logic [CW:0]   cc_x, tgt_x, diff;
  logic          busy_d, done_d, up, rise;

  div_clk_edge u_edge (
    .clk     (clk),
    .rst     (rst),
    .div_clk (div_clk),
    .rise    (rise)
  );

  assign req.req_ready = (state_q == IDLE);

  // diff > STEP whenever stepped is used, so the CW-bit step cannot wrap
  always_comb begin
    cc_x    = {1'b0, count_control};
    tgt_x   = {1'b0, tgt_q};
    up      = (tgt_x > cc_x);
    diff    = up ? (tgt_x - cc_x) : (cc_x - tgt_x);
    stepped = up ? (count_control + STEP) : (count_control - STEP);
    req_tgt = (req.req_count < MIN_COUNT) ? MIN_COUNT : req.req_count;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    cc_d    = count_control;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          tgt_d = req_tgt;
          if (req_tgt == count_control) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      RAMP: begin
        // abort takes priority over a step landing on the same edge
        if (req.req_abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (rise) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (diff <= STEP_X) begin
              cc_d    = tgt_q;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              cc_d = stepped;
            end
          end else begin
            cnt_d = cnt_q + EW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tgt_q         <= INIT_COUNT;
      count_control <= INIT_COUNT;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tgt_q         <= tgt_d;
      count_control <= cc_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_div_ramp_ctrl.sv
// Scoreboard bench for div_ramp_ctrl: stimulus pushes expected count updates,
// a negedge monitor pops them whenever count_control changes or done pulses.
module tb_div_ramp_ctrl;

  localparam int unsigned   CW    = 26;
  localparam int unsigned   DWELL = 2;
  localparam logic [CW-1:0] INIT  = 100;
  localparam logic [CW-1:0] STEP  = 10;
  localparam logic [CW-1:0] MINC  = 1;

  typedef struct {
    int unsigned val;
    bit          fin;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          div_clk = 1'b0;
  logic [CW-1:0] count_control;
  logic          busy, done;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_done_cyc = -10;
  int          acc_cyc = 0;
  int unsigned mcur = INIT;
  bit          dc_manual = 1'b0;

  div_ramp_ctrl_if #(.CW(CW)) rif ();

  div_ramp_ctrl #(
    .CW         (CW),
    .INIT_COUNT (INIT),
    .MIN_COUNT  (MINC),
    .STEP       (STEP),
    .DWELL      (DWELL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .div_clk       (div_clk),
    .req           (rif.slave),
    .count_control (count_control),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // free-running divider output with random spacing between rises
  initial forever begin
    @(posedge clk);
    #1;
    if (!dc_manual && $urandom_range(0, 2) == 0) div_clk = ~div_clk;
  end

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // reference: walk from the current value to the target in STEP-sized moves
  task automatic push_ramp(input int unsigned tgt);
    int unsigned cur = mcur;
    if (tgt == cur) q.push_back('{val: cur, fin: 1'b1});
    while (cur != tgt) begin
      if (tgt > cur) cur = (tgt - cur <= STEP) ? tgt : cur + STEP;
      else           cur = (cur - tgt <= STEP) ? tgt : cur - STEP;
      q.push_back('{val: cur, fin: (cur == tgt)});
    end
    mcur = tgt;
  endtask

  task automatic accept(input int unsigned v, input bit do_push, input bit held);
    int n = 0;
    int unsigned t;
    t = (v < MINC) ? MINC : v;
    @(posedge clk);
    #1;
    rif.req_valid = 1'b1;
    rif.req_count = CW'(v);
    forever begin
      @(negedge clk);
      if (held) check("ready_vs_busy", rif.req_ready, !busy);
      if (rif.req_ready) break;
      n++;
      if (n > 3000) begin
        timeout("accept");
        rif.req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    if (do_push) push_ramp(t);
    #1;
    rif.req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy && q.size() == 0) break;
      n++;
      if (n > 3000) begin
        timeout(name);
        q.delete();
        break;
      end
    end
    repeat (3) @(negedge clk);
    check({name, "_final"}, count_control, mcur);
  endtask

  task automatic wait_cc(input int unsigned v);
    int n = 0;
    forever begin
      @(negedge clk);
      if (count_control == CW'(v)) break;
      n++;
      if (n > 3000) begin
        timeout("wait_cc");
        break;
      end
    end
  endtask

  task automatic dc_set(input logic v);
    @(posedge clk);
    #1;
    div_clk = v;
  endtask

  // monitor: reconstruct what the DUT sampled at each posedge from negedge samples
  initial begin
    logic [CW-1:0] prev_cc;
    bit prev_busy, dc_a, dc_b;
    int rises;
    exp_t e;
    prev_cc = INIT; prev_busy = 0; dc_a = 0; dc_b = 0; rises = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cc = count_control; prev_busy = 0; dc_a = 0; dc_b = 0; rises = 0;
      end else begin
        if (prev_busy && dc_a && !dc_b) rises++;
        if (!prev_busy) rises = 0;
        if (count_control != prev_cc || done) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got value %0d done %0b with nothing expected (t=%0t)",
                     count_control, done, $time);
          end else begin
            e = q.pop_front();
            check("value", count_control, e.val);
            check("done", done, e.fin);
            check("busy_with_update", busy, !e.fin);
            if (prev_busy) check("dwell_rises", rises, DWELL);
          end
          rises = 0;
          if (done) last_done_cyc = cyc;
        end
        dc_b = dc_a; dc_a = div_clk; prev_busy = busy; prev_cc = count_control;
      end
    end
  end

  initial begin
    rif.req_valid = 1'b0;
    rif.req_count = '0;
    rif.req_abort = 1'b0;

    #1 rst = 1'b1;
    #2;
    check("rst_count", count_control, INIT);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", rif.req_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_count", count_control, INIT);
    check("post_rst_ready", rif.req_ready, 1);

    accept(100, 1, 0);          // same-value request
    wait_idle("same_value");
    accept(130, 1, 0);
    wait_idle("up_130");

    // asynchronous reset in the middle of a ramp
    accept(60, 1, 0);
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    q.delete();
    mcur = INIT;
    #1;
    check("midrst_count", count_control, INIT);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", rif.req_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    accept(75, 1, 0);
    wait_idle("down_75");
    accept(0, 1, 0);            // clamped to MIN_COUNT
    wait_idle("clamp_min");
    accept(100, 1, 0);
    wait_idle("back_100");

    // abort after the first step of 100 -> 140
    accept(140, 0, 0);
    q.push_back('{val: 110, fin: 1'b0});
    wait_cc(110);
    @(posedge clk);
    #1 rif.req_abort = 1'b1;
    @(posedge clk);
    #1 rif.req_abort = 1'b0;
    mcur = 110;
    repeat (12) @(negedge clk);
    check("abort1_count", count_control, 110);
    check("abort1_busy", busy, 0);
    check("abort1_ready", rif.req_ready, 1);
    check("abort1_queue", q.size(), 0);

    // abort landing on the same edge as the final step of 110 -> 125
    dc_manual = 1'b1;
    dc_set(1'b0);
    dc_set(1'b0);
    accept(125, 0, 0);
    q.push_back('{val: 120, fin: 1'b0});
    div_clk = 1'b1;
    dc_set(1'b0);
    dc_set(1'b1);
    dc_set(1'b0);
    dc_set(1'b1);
    dc_set(1'b0);
    @(posedge clk);
    #1;
    div_clk = 1'b1;
    rif.req_abort = 1'b1;
    @(posedge clk);
    #1;
    div_clk = 1'b0;
    rif.req_abort = 1'b0;
    mcur = 120;
    repeat (6) @(negedge clk);
    check("abort2_count", count_control, 120);
    check("abort2_busy", busy, 0);
    check("abort2_queue", q.size(), 0);
    dc_manual = 1'b0;

    // request held during a ramp is taken on the cycle after done
    accept(150, 1, 0);
    accept(50, 1, 1);
    check("held_accept_cycle", acc_cyc, last_done_cyc + 1);
    wait_idle("held_50");

    for (int i = 0; i < 12; i++) begin
      int unsigned v;
      v = ($urandom_range(0, 3) == 0) ? mcur : $urandom_range(0, 220);
      accept(v, 1, 0);
      wait_idle("random");
    end

    check("end_queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
